msg_pack_register: RTL and testbench

MSG_PACK_REGISTER -- requirements
Module: msg_pack_register

---
 rtl/msg_pack_register.sv | 154 +++++++++++++++
 tb/tb_msg_pack_register.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/msg_pack_register.sv
// msg_pack_register: packs variable-length channel messages into fixed frames of control-tagged blocks
module msg_pack_register #(
  parameter int NumChannels  = 2,
  parameter int BlockSize    = 8,
  parameter int NumBlocks    = 8,
  parameter int ClkDiv       = 4,
  parameter int FlushTimeout = 16,
  localparam int LW = $clog2(NumBlocks + 1)
) (
  input  logic                                              clk_i,
  input  logic                                              rst_ni,
  input  logic [NumChannels-1:0]                            valid_i,
  output logic [NumChannels-1:0]                            ready_o,
  input  logic [NumChannels-1:0][NumBlocks*BlockSize-1:0]   data_i,
  input  logic [NumChannels-1:0][LW-1:0]                    len_i,
  output logic                                              valid_o,
  input  logic                                              ready_i,
  output logic [NumBlocks*(BlockSize+1)-1:0]                data_o,
  output logic [LW-1:0]                                     num_msgs_o,
  output logic                                              drop_o
);
  localparam int PW = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int TW = $clog2(FlushTimeout + 1);
  localparam int GW = $clog2(ClkDiv + 1);

  typedef enum logic [1:0] {IDLE, FILL, SEND} state_e;

  state_e state_q, state_d;
  logic [LW-1:0] used_q, used_d, num_msgs_q, num_msgs_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [NumBlocks-1:0][BlockSize:0] frame_q, frame_d, frame_w;
  logic valid_q;
  logic [NumBlocks*(BlockSize+1)-1:0] data_q;
  logic [LW-1:0] nmsg_out_q;

  logic any, hi_any, open, illegal, fits, accept, drop, no_fit, timeout, go_send, hs;
  logic [PW-1:0] win, hi_win, lo_win;
  logic [LW-1:0] win_len, used_w, nmsg_w;
  logic [LW:0] sum;

  // round-robin pick: lowest valid channel at or above the pointer, else lowest valid overall
  always_comb begin
    hi_any = 1'b0;
    hi_win = '0;
    lo_win = '0;
    for (int c = NumChannels - 1; c >= 0; c--) begin
      if (valid_i[c]) lo_win = PW'(c);
      if (valid_i[c] && PW'(c) >= ptr_q) begin
        hi_any = 1'b1;
        hi_win = PW'(c);
      end
    end
  end

  assign any = |valid_i;
  assign win = hi_any ? hi_win : lo_win;
  assign win_len = len_i[win];

  // classify the winner; the sum is one bit wider so used+len cannot wrap
  always_comb begin
    open    = rst_ni && state_q != SEND;
    sum     = {1'b0, used_q} + {1'b0, win_len};
    illegal = win_len == '0 || win_len > LW'(NumBlocks);
    fits    = sum <= (LW+1)'(NumBlocks);
    accept  = open && any && !illegal && fits;
    drop    = open && any && illegal;
    no_fit  = open && any && !illegal && !fits;
    hs      = state_q == SEND && ready_i;
    used_w  = accept ? sum[LW-1:0] : used_q;
    nmsg_w  = num_msgs_q + LW'(accept);
    timeout = state_q == FILL && timer_q == TW'(FlushTimeout - 1);
    go_send = open && gap_q == '0 && used_w != '0 &&
              (used_w == LW'(NumBlocks) || no_fit || timeout);
  end

  // frame with the accepted message written at blocks used..used+len-1
  always_comb begin
    int off;
    off = 0;
    frame_w = frame_q;
    for (int b = 0; b < NumBlocks; b++) begin
      off = b - int'(used_q);
      if (accept && off >= 0 && off < int'(win_len))
        frame_w[b] = {BlockSize'(data_i[win] >> (off * BlockSize)), off == 0};
    end
  end

  // next values for the frame bookkeeping, timer, gap counter and arbiter pointer
  always_comb begin
    frame_d    = hs ? '0 : frame_w;
    used_d     = hs ? '0 : used_w;
    num_msgs_d = hs ? '0 : nmsg_w;
    timer_d    = hs ? '0 :
                 ((state_q == FILL || accept) && timer_q != TW'(FlushTimeout - 1)) ? timer_q + 1'b1 : timer_q;
    gap_d      = hs ? GW'(ClkDiv - 1) : gap_q != '0 ? gap_q - 1'b1 : gap_q;
    ptr_d      = !(accept || drop) ? ptr_q : win == PW'(NumChannels - 1) ? '0 : win + 1'b1;
  end

  // next-state decode
  always_comb begin
    state_d = hs ? IDLE : go_send ? SEND : accept ? FILL : state_q;
  end

  // per-channel accept and drop pulse
  always_comb begin
    ready_o = '0;
    for (int c = 0; c < NumChannels; c++) ready_o[c] = (accept || drop) && win == PW'(c);
    drop_o = drop;
  end

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  end

  // frame accumulation registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_q    <= '0;
      used_q     <= '0;
      num_msgs_q <= '0;
      timer_q    <= '0;
      gap_q      <= '0;
      ptr_q      <= '0;
    end else begin
      frame_q    <= frame_d;
      used_q     <= used_d;
      num_msgs_q <= num_msgs_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
      ptr_q      <= ptr_d;
    end
  end

  // registered frame output, captured on entry to SEND and held until handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      nmsg_out_q <= '0;
    end else begin
      valid_q    <= go_send || (valid_q && !hs);
      data_q     <= go_send ? frame_w : data_q;
      nmsg_out_q <= go_send ? nmsg_w : nmsg_out_q;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign num_msgs_o = nmsg_out_q;
endmodule

// File: tb/tb_msg_pack_register.sv
// tb_msg_pack_register: directed scenarios with a frame scoreboard and an independent output monitor
module tb_msg_pack_register;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] valid_i, ready_o;
  logic [1:0][63:0] data_i;
  logic [1:0][3:0] len_i;
  logic valid_o, ready_i, drop_o;
  logic [71:0] data_o;
  logic [3:0] num_msgs_o;

  msg_pack_register dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .len_i(len_i), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .num_msgs_o(num_msgs_o), .drop_o(drop_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [71:0] data;
    int nmsg;
    int rise;
    int hs;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [71:0] put(input logic [71:0] f, input int pos, input int len, input logic [63:0] d);
    logic [71:0] r;
    r = f;
    for (int k = 0; k < len; k++) r[(pos + k) * 9 +: 9] = {d[k * 8 +: 8], k == 0};
    return r;
  endfunction

  // monitor: pops an expectation when a frame appears, checks hold stability and the handshake
  logic prev_v = 1'b0;
  logic have = 1'b0;
  logic [71:0] hold;
  exp_t cur;
  int last_hs = -1;
  always @(negedge clk) begin
    if (!rst_n) prev_v = 1'b0;
    else begin
      if (valid_o && !prev_v) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          have = 1'b0;
          $display("FAIL unexpected_frame: got %h expected none (cycle %0d)", data_o, cyc);
        end else begin
          cur = sb.pop_front();
          have = 1'b1;
          if (cur.rise >= 0) chk("rise_cycle", cyc, cur.rise);
        end
        hold = data_o;
      end else if (valid_o) chk("hold_data", data_o, hold);
      if (valid_o && ready_i) begin
        if (have) begin
          chk("frame_data", data_o, cur.data);
          chk("num_msgs", num_msgs_o, cur.nmsg);
          if (cur.hs >= 0) chk("hs_cycle", cyc, cur.hs);
        end
        if (last_hs >= 0) chk("hs_spacing_ge4", (cyc - last_hs) >= 4, 1);
        last_hs = cyc;
      end
      prev_v = valid_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input int len, input logic [63:0] d, output int acc);
    acc = -1;
    valid_i[ch] = 1'b1;
    len_i[ch] = 4'(len);
    data_i[ch] = d;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ready_o[ch]) begin
        acc = cyc;
        @(posedge clk);
        #1;
        valid_i[ch] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    failures++;
    $display("FAIL send_timeout: ch%0d got no ready expected ready within 100 cycles", ch);
    valid_i[ch] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int start, a0, a1;
    logic [63:0] de [3];
    de[0] = 64'h1122334455667788;
    de[1] = 64'h99AABBCCDDEEFF00;
    de[2] = 64'h0F1E2D3C4B5A6978;
    ready_i = 1'b1;
    data_i = '0;
    len_i = {4'd2, 4'd2};
    valid_i = 2'b11;
    @(negedge clk);
    chk("rst_valid_o", valid_o, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_num_msgs", num_msgs_o, 0);
    chk("rst_drop_o", drop_o, 0);
    chk("rst_ready_o", ready_o, 0);
    valid_i = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);

    // two messages completing a frame exactly
    start = cyc;
    fork
      send(0, 3, 64'hEEDDCCBBAA030201, a0);
      send(1, 5, 64'hF0F1F21514131211, a1);
    join
    chk("A_ch0_acc", a0, start);
    chk("A_ch1_acc", a1, start + 1);
    sb.push_back('{put(put(72'h0, 0, 3, 64'hEEDDCCBBAA030201), 3, 5, 64'hF0F1F21514131211), 2, a1 + 1, a1 + 1});
    tick(8);

    // illegal length on ch1 is dropped without touching the frame
    valid_i[1] = 1'b1;
    len_i[1] = 4'd0;
    data_i[1] = 64'hDEADBEEFDEADBEEF;
    @(negedge clk);
    chk("F_drop_pulse", drop_o, 1);
    chk("F_drop_ready", ready_o, 2'b10);
    @(posedge clk);
    #1 valid_i[1] = 1'b0;
    @(negedge clk);
    chk("F_drop_clear", drop_o, 0);
    @(posedge clk);
    #1;
    start = cyc;
    fork
      send(0, 4, 64'h0000000044434241, a0);
      send(1, 4, 64'h0000000084838281, a1);
    join
    chk("F_ptr_ch0_first", a0, start);
    sb.push_back('{put(put(72'h0, 0, 4, 64'h0000000044434241), 4, 4, 64'h0000000084838281), 2, a1 + 1, a1 + 1});
    tick(8);

    // non-fitting message defers to the next frame
    send(0, 6, 64'hABAB161514131211, a0);
    sb.push_back('{put(72'h0, 0, 6, 64'hABAB161514131211), 1, a0 + 2, a0 + 2});
    send(0, 4, 64'hCDCDCDCD24232221, a1);
    chk("B_defer_acc", a1, a0 + 3);
    sb.push_back('{put(72'h0, 0, 4, 64'hCDCDCDCD24232221), 1, a1 + 16, a1 + 16});
    tick(25);

    // lone short message flushed by the timeout
    send(1, 2, 64'h7777777777773231, a0);
    sb.push_back('{put(72'h0, 0, 2, 64'h7777777777773231), 1, a0 + 16, a0 + 16});
    tick(24);

    // backpressure: frame held for 10 cycles, nothing accepted meanwhile
    ready_i = 1'b0;
    send(0, 8, 64'h5857565554535251, a0);
    sb.push_back('{put(72'h0, 0, 8, 64'h5857565554535251), 1, a0 + 1, a0 + 11});
    valid_i[1] = 1'b1;
    len_i[1] = 4'd2;
    data_i[1] = 64'h0000000000006261;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("D_no_ready", ready_o, 0);
      @(posedge clk);
      #1;
    end
    ready_i = 1'b1;
    send(1, 2, 64'h0000000000006261, a1);
    chk("D_acc_after_hs", a1, a0 + 12);
    sb.push_back('{put(72'h0, 0, 2, 64'h0000000000006261), 1, a1 + 16, -1});
    tick(24);

    // back-to-back full frames are spaced by the gap counter
    for (int j = 0; j < 3; j++) begin
      send(0, 8, de[j], a0);
      sb.push_back('{put(72'h0, 0, 8, de[j]), 1, (j == 0) ? a0 + 1 : a0 + 4, -1});
    end
    tick(8);

    // reset mid-frame discards the partial frame
    send(0, 2, 64'h0000000000009291, a0);
    tick(3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("R_valid_in_rst", valid_o, 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    send(1, 8, 64'hA8A7A6A5A4A3A2A1, a1);
    sb.push_back('{put(72'h0, 0, 8, 64'hA8A7A6A5A4A3A2A1), 1, a1 + 1, a1 + 1});
    tick(20);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
